// File: rtl/mult2x2_seq_ctrl.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier built on one external 2x2 core.
// Latency: out_valid rises D*D cycles after the accepting edge; D*D+2 cycles per product unstalled.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until the output handshake.
module mult2x2_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [1:0]           core_a,
    output logic [1:0]           core_b,
    input  logic [3:0]           core_p,
    output logic                 busy
);

    localparam int D  = WIDTH / 2;
    localparam int CW = $clog2(D);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   i;
    logic [CW-1:0]   j;

    logic [PW-1:0]   pp_shifted;
    logic [PW-1:0]   acc_next;
    logic [CW:0]     pos_sum;
    logic [CW-1:0]   i_next;
    logic [CW-1:0]   j_next;
    logic            last_pair;

    // Selects 2-bit digit k of an operand.
    function automatic logic [1:0] digit(input logic [WIDTH-1:0] v, input logic [CW-1:0] k);
        logic [WIDTH-1:0] s;
        s = v >> {k, 1'b0};
        return s[1:0];
    endfunction

    // Partial-product alignment, accumulation and next digit-pair indices (j fastest).
    always_comb begin
        pos_sum    = {1'b0, i} + {1'b0, j};
        pp_shifted = PW'(core_p) << {pos_sum, 1'b0};
        acc_next   = acc + pp_shifted;
        last_pair  = (i == LAST) && (j == LAST);
        i_next     = i;
        j_next     = j + CW'(1);
        if (j == LAST) begin
            j_next = '0;
            i_next = i + CW'(1);
        end
    end

    // Controller FSM; every output, including the core digit drive, is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_p     <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            core_a    <= '0;
            core_b    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                        acc      <= '0;
                        i        <= '0;
                        j        <= '0;
                        // Present pair (0,0) in the first RUN cycle.
                        core_a   <= in_a[1:0];
                        core_b   <= in_b[1:0];
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    i      <= i_next;
                    j      <= j_next;
                    core_a <= digit(a_reg, i_next);
                    core_b <= digit(b_reg, j_next);
                    if (last_pair) begin
                        out_p     <= acc_next;
                        out_valid <= 1'b1;
                        core_a    <= '0;
                        core_b    <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // out_p is left untouched so it survives the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult2x2_seq_ctrl.sv
// Bench for mult2x2_seq_ctrl: WIDTH=8 and WIDTH=4 instances, each with a behavioural 2x2 core.
// Expected products are pushed to a scoreboard on accept and popped at the output handshake.
// Latency, hold-under-stall, reset abort and operand-capture behaviour are checked directly.
module tb_mult2x2_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  in_a, in_b;
    logic [15:0] out_p;
    logic [1:0]  core_a, core_b;
    logic [3:0]  core_p;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0]  in_a4, in_b4;
    logic [7:0]  out_p4;
    logic [1:0]  core_a4, core_b4;
    logic [3:0]  core_p4;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    assign core_p  = {2'b00, core_a}  * {2'b00, core_b};
    assign core_p4 = {2'b00, core_a4} * {2'b00, core_b4};

    mult2x2_seq_ctrl #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .core_a(core_a), .core_b(core_b), .core_p(core_p), .busy(busy)
    );

    mult2x2_seq_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_p(out_p4),
        .core_a(core_a4), .core_b(core_b4), .core_p(core_p4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, drives one operand pair for exactly one accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", 64'(n < 50), 64'(1));
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        sb.push_back(16'(a) * 16'(b));
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", 64'(busy), 64'(1));
        check("in_ready_after_accept", 64'(in_ready), 64'(0));
    endtask

    // Counts cycles from the current point until out_valid, bounded.
    task automatic wait_out(input int already, input string tag);
        int n;
        n = already;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'(16));
    endtask

    // Holds out_ready low for 'stall' cycles checking the output is held, then handshakes.
    task automatic drain(input int stall);
        logic [15:0] exp;
        exp = (sb.size() > 0) ? sb[0] : 16'hxxxx;
        for (int k = 0; k < stall; k++) begin
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_out_p", 64'(out_p), 64'(exp));
            check("stall_in_ready", 64'(in_ready), 64'(0));
            tick();
        end
        out_ready = 1'b1;
        if (sb.size() > 0) exp = sb.pop_front();
        check("out_p", 64'(out_p), 64'(exp));
        check("out_valid_at_hs", 64'(out_valid), 64'(1));
        tick();
        out_ready = 1'b0;
        check("out_valid_after_hs", 64'(out_valid), 64'(0));
        check("in_ready_after_hs", 64'(in_ready), 64'(1));
        check("busy_after_hs", 64'(busy), 64'(0));
        check("out_p_retained", 64'(out_p), 64'(exp));
    endtask

    initial begin
        logic [1:0] exp_ca4[4];
        logic [1:0] exp_cb4[4];
        logic [7:0] ra, rb;
        int n;

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; out_ready4 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_p", 64'(out_p), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_core_a", 64'(core_a), 64'(0));
        check("rst_core_b", 64'(core_b), 64'(0));
        check("rst_in_ready4", 64'(in_ready4), 64'(1));

        // Max x max, no backpressure.
        send(8'hFF, 8'hFF);
        wait_out(0, "latency_ff");
        check("ff_product", 64'(out_p), 64'(16'hFE01));
        drain(0);

        // WIDTH=4 digit sequencing: 0xB x 0x6.
        exp_ca4 = '{2'd3, 2'd3, 2'd2, 2'd2};
        exp_cb4 = '{2'd2, 2'd1, 2'd2, 2'd1};
        in_valid4 = 1'b1; in_a4 = 4'hB; in_b4 = 4'h6;
        tick();
        in_valid4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("w4_core_a", 64'(core_a4), 64'(exp_ca4[k]));
            check("w4_core_b", 64'(core_b4), 64'(exp_cb4[k]));
            check("w4_out_valid_low", 64'(out_valid4), 64'(0));
            tick();
        end
        check("w4_out_valid", 64'(out_valid4), 64'(1));
        check("w4_out_p", 64'(out_p4), 64'(8'h42));
        check("w4_core_a_done", 64'(core_a4), 64'(0));
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        check("w4_out_valid_after_hs", 64'(out_valid4), 64'(0));
        check("w4_in_ready_after_hs", 64'(in_ready4), 64'(1));

        // Zero product held under 5 cycles of backpressure.
        send(8'h00, 8'hA5);
        wait_out(0, "latency_zero");
        check("zero_product", 64'(out_p), 64'(0));
        drain(5);

        // Reset in the 7th RUN cycle discards the partial result.
        send(8'h9C, 8'h37);
        void'(sb.pop_back());
        for (int k = 0; k < 6; k++) tick();
        check("midrun_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'(1));
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_out_p", 64'(out_p), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        send(8'h12, 8'h34);
        wait_out(0, "latency_after_abort");
        check("after_abort_product", 64'(out_p), 64'(16'h03A8));
        drain(1);

        // in_valid held high with operands changed mid-RUN; second pair accepted after handshake.
        in_valid = 1'b1; in_a = 8'h5A; in_b = 8'hC3;
        sb.push_back(16'(8'h5A) * 16'(8'hC3));
        tick();
        for (int k = 0; k < 3; k++) tick();
        in_a = 8'h77; in_b = 8'hE1;
        wait_out(3, "latency_hold1");
        drain(2);
        sb.push_back(16'(8'h77) * 16'(8'hE1));
        tick();
        in_valid = 1'b0;
        check("hold2_accepted", 64'(busy), 64'(1));
        wait_out(0, "latency_hold2");
        drain(0);

        // Random operands with random output stalls.
        for (int t = 0; t < 1000; t++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send(ra, rb);
            wait_out(0, "latency_rand");
            drain(int'($urandom_range(0, 3)));
        end

        // Nothing left outstanding.
        n = sb.size();
        check("scoreboard_empty", 64'(n), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
